drive_mode_arbiter: RTL and testbench
=====================================

# drive_mode_arbiter

Top-level mode controller for the car: handles power on/off by long press, picks one of the manual, semi-auto and auto driving sub-controllers, and drives their enable lines (`manual_mode_on`, `semi_auto_mode_on`, `auto_mode_on`). It multiplexes the 4-bit motion command of the active sub-controller onto the motor outputs. On every mode change it inserts a timed stop (handover), so two controllers never drive the motors in consecutive cycles.

## Interface
- `TICK_DIV`, 1_000_000: `clk` cycles per internal tick (100 Hz at 100 MHz).
- `POWER_HOLD_TICKS`, 100: ticks `power_button` must be held to toggle power (1 s).
- `HANDOVER_TICKS`, 50: ticks of forced stop between modes (0.5 s).
- `clk` in 1: system clock. One clock domain only.
- `reset` in 1: synchronous, active-high.
- `power_button` in 1: level, already debounced.
- `mode_sel` in 2: 00 none, 01 manual, 10 semi-auto, 11 auto.
- `manual_cmd`, `semi_cmd`, `auto_cmd` in 4 each: `{move_backward,move_forward,turn_left,turn_right}`.
- `power_on` out 1: car powered.
- `manual_mode_on`, `semi_auto_mode_on`, `auto_mode_on` out 1 each: sub-controller enables, one-hot or all zero.
- `move_backward`, `move_forward`, `turn_left`, `turn_right` out 1 each: motor commands.
- `mode_state` out 3: current FSM state, for LEDs.

## Operation
- States:
  - OFF = 000
  - IDLE = 001
  - HANDOVER = 010
  - MANUAL = 011
  - SEMI = 100
  - AUTO = 101
- Power toggle:
  - `hold_cnt` clears in any cycle with `power_button` low.
  - On each tick with the button high and `armed` = 1, `hold_cnt` increments.
  - When it reaches `POWER_HOLD_TICKS`, a toggle fires, `armed` drops and `hold_cnt` clears.
  - `armed` is set again only after the button is seen low.
  - Toggle in OFF goes to IDLE. Toggle in any other state goes to OFF.
- IDLE: if `mode_sel` ≠ 00, latch `target` = `mode_sel` and go to HANDOVER.
- MANUAL, SEMI, AUTO: if `mode_sel` ≠ own code, latch `target` = `mode_sel` and go to HANDOVER. A target of 00 also goes through HANDOVER and then to IDLE.
- HANDOVER:
  - `ho_cnt` counts ticks.
  - If `mode_sel` ≠ `target`, relatch `target` and clear `ho_cnt`, so the handover restarts.
  - When `ho_cnt` reaches `HANDOVER_TICKS`, enter the state for `target`.
- Priority within one cycle: reset > power toggle > mode change > handover completion.
- Enables:
  - `manual_mode_on` = 1 only in MANUAL.
  - `semi_auto_mode_on` = 1 only in SEMI.
  - `auto_mode_on` = 1 only in AUTO.
  - `power_on` = 1 in every state except OFF.
- Motion outputs:
  - In MANUAL, SEMI or AUTO they copy the matching cmd.
  - In any other state they are 0000.
- Conflict masking:
  - A cmd with both backward and forward set forces both to 0.
  - A cmd with both left and right set forces both to 0.
  - The other pair passes through unchanged.
- Unused state codes (110, 111) recover to OFF on the next clk.

## Timing
- Reset values:
  - State OFF, `target` 00, all counters 0, `armed` 1.
  - All outputs 0, `mode_state` 000.
- Tick: one-`clk` pulse, every `TICK_DIV` cycles counted from the release of reset.
- All outputs are registered.
  - State and enables change on the `clk` edge after the deciding condition.
  - Cmd → motor output latency is 1 `clk` in an active mode.
- On a mode exit, enables and motors are 0 from the first HANDOVER cycle.
- The new enable asserts in the same cycle the new state is entered.
- A power toggle fires on the clk edge after the qualifying tick.
- Reset mid-operation (e.g. mid-handover or mid-hold) returns to reset values at the next edge. A button still held after reset does not toggle until `POWER_HOLD_TICKS` fresh ticks have been counted.

## Structure
- Shared package `drive_pkg`:
  - State encoding localparams.
  - Cmd bit-index constants (BWD = 3, FWD = 2, LEFT = 1, RIGHT = 0).
  - `mode_sel` codes.
- Sub-module `tick_gen`:
  - Parameter `DIV`, ports `clk`, `reset`, `tick`.
  - Reusable by the driving controllers in place of per-module clock dividers.
- The arbiter is one FSM plus the hold and handover counters. Widths are `$clog2` of the parameters plus 1.

## Test plan
Bench parameters: `TICK_DIV` = 4, `POWER_HOLD_TICKS` = 3, `HANDOVER_TICKS` = 2.
- Power on: hold `power_button` for 12 clk → `power_on` rises on the edge after the 3rd tick and `mode_state` = 001. Keep holding for 40 clk → no toggle. Release, hold 12 clk again → OFF.
- Short press: hold 8 clk (2 ticks), release → stays OFF and `hold_cnt` returns to 0.
- Mode entry: IDLE, `mode_sel` = 01, `manual_cmd` = 0100 → HANDOVER with outputs 0000 for 2 ticks, then MANUAL with `manual_mode_on` = 1 and `move_forward` = 1 one clk after the cmd.
- Handover retarget: during HANDOVER change `mode_sel` 10→11 → counter restarts and AUTO is entered 2 full ticks after the change. `semi_auto_mode_on` never pulses.
- Conflict masking: MANUAL with cmd 1110 → outputs 0010. Cmd 0011 → outputs 0000.
- Reset mid-handover: assert `reset` for 1 clk → all outputs 0 and `mode_state` 000 on the next edge.

Source files
------------

// File: rtl/drive_mode_arbiter_pkg.sv
// drive_pkg: definitions shared by the drive mode arbiter and the driving sub-controllers.
//   state_t        : arbiter FSM state encoding, also shown on the mode LEDs
//   CMD_*          : bit positions inside a 4-bit motion command {bwd,fwd,left,right}
//   SEL_*          : mode_sel codes
//   mask_cmd       : clears both halves of a contradictory direction pair
//   state_for_sel  : active state selected by a mode_sel code (none -> IDLE)
//   sel_for_state  : mode_sel code that keeps an active state selected
package drive_pkg;

   typedef enum logic [2:0] {
      ST_OFF      = 3'b000,
      ST_IDLE     = 3'b001,
      ST_HANDOVER = 3'b010,
      ST_MANUAL   = 3'b011,
      ST_SEMI     = 3'b100,
      ST_AUTO     = 3'b101
   } state_t;

   localparam int CMD_BWD   = 3;
   localparam int CMD_FWD   = 2;
   localparam int CMD_LEFT  = 1;
   localparam int CMD_RIGHT = 0;

   localparam logic [1:0] SEL_NONE   = 2'b00;
   localparam logic [1:0] SEL_MANUAL = 2'b01;
   localparam logic [1:0] SEL_SEMI   = 2'b10;
   localparam logic [1:0] SEL_AUTO   = 2'b11;

   // A pair asking for both directions at once is treated as "neither";
   // the other pair is left untouched.
   function automatic logic [3:0] mask_cmd(input logic [3:0] cmd);
      logic [3:0] masked;
      masked = cmd;
      if (cmd[CMD_BWD] && cmd[CMD_FWD]) begin
         masked[CMD_BWD] = 1'b0;
         masked[CMD_FWD] = 1'b0;
      end
      if (cmd[CMD_LEFT] && cmd[CMD_RIGHT]) begin
         masked[CMD_LEFT]  = 1'b0;
         masked[CMD_RIGHT] = 1'b0;
      end
      return masked;
   endfunction

   function automatic state_t state_for_sel(input logic [1:0] sel);
      state_t st;
      case (sel)
         SEL_MANUAL: st = ST_MANUAL;
         SEL_SEMI:   st = ST_SEMI;
         SEL_AUTO:   st = ST_AUTO;
         default:    st = ST_IDLE;
      endcase
      return st;
   endfunction

   function automatic logic [1:0] sel_for_state(input state_t st);
      logic [1:0] sel;
      case (st)
         ST_MANUAL: sel = SEL_MANUAL;
         ST_SEMI:   sel = SEL_SEMI;
         ST_AUTO:   sel = SEL_AUTO;
         default:   sel = SEL_NONE;
      endcase
      return sel;
   endfunction

endpackage

// File: rtl/drive_mode_arbiter_if.sv
// drive_mode_arbiter_if: mode selection, sub-controller commands and arbiter outputs.
//   mode_sel                     : requested mode (00 none, 01 manual, 10 semi, 11 auto)
//   manual_cmd/semi_cmd/auto_cmd : {move_backward,move_forward,turn_left,turn_right}
//   power_on                     : car powered
//   *_mode_on                    : sub-controller enables, one-hot or all zero
//   move_*/turn_*                : motor commands
//   mode_state                   : arbiter FSM state for the LEDs
// master = the arbiter side, slave = the sub-controller / car side.
interface drive_mode_arbiter_if;
   logic [1:0] mode_sel;
   logic [3:0] manual_cmd;
   logic [3:0] semi_cmd;
   logic [3:0] auto_cmd;
   logic       power_on;
   logic       manual_mode_on;
   logic       semi_auto_mode_on;
   logic       auto_mode_on;
   logic       move_backward;
   logic       move_forward;
   logic       turn_left;
   logic       turn_right;
   logic [2:0] mode_state;

   modport master (
      input  mode_sel, manual_cmd, semi_cmd, auto_cmd,
      output power_on, manual_mode_on, semi_auto_mode_on, auto_mode_on,
      output move_backward, move_forward, turn_left, turn_right, mode_state
   );

   modport slave (
      output mode_sel, manual_cmd, semi_cmd, auto_cmd,
      input  power_on, manual_mode_on, semi_auto_mode_on, auto_mode_on,
      input  move_backward, move_forward, turn_left, turn_right, mode_state
   );
endinterface

// File: rtl/drive_mode_arbiter_tick_gen.sv
// tick_gen: divides clk down to a one-cycle tick pulse every DIV cycles,
// counted from the release of reset.
//   clk   : system clock
//   reset : synchronous, active-high
//   tick  : one-clk pulse, high in the DIV-th cycle of each period
module tick_gen #(
   parameter int DIV = 1_000_000
) (
   input  logic clk,
   input  logic reset,
   output logic tick
);
   localparam int            CW   = $clog2(DIV) + 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] cnt_reg;

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_reg <= '0;
      end else if (cnt_reg == LAST) begin
         cnt_reg <= '0;
      end else begin
         cnt_reg <= cnt_reg + 1'b1;
      end
   end

   // Decoded straight from a register, so it is glitch-free within the domain.
   assign tick = (cnt_reg == LAST);
endmodule

// File: rtl/drive_mode_arbiter.sv
// drive_mode_arbiter: power on/off by long press, selection of the manual,
// semi-auto or auto sub-controller, and multiplexing of its motion command onto
// the motors. Every mode change passes through a timed HANDOVER stop so two
// controllers never drive the motors in consecutive cycles.
//   clk          : system clock
//   reset        : synchronous, active-high
//   power_button : debounced level; held POWER_HOLD_TICKS ticks toggles power
//   bus          : mode_sel, sub-controller commands and all registered outputs
module drive_mode_arbiter
   import drive_pkg::*;
#(
   parameter int TICK_DIV         = 1_000_000,
   parameter int POWER_HOLD_TICKS = 100,
   parameter int HANDOVER_TICKS   = 50
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  power_button,
   drive_mode_arbiter_if.master  bus
);
   localparam int            HW        = $clog2(POWER_HOLD_TICKS) + 1;
   localparam int            OW        = $clog2(HANDOVER_TICKS) + 1;
   localparam logic [HW-1:0] HOLD_LAST = HW'(POWER_HOLD_TICKS - 1);
   localparam logic [OW-1:0] HO_LAST   = OW'(HANDOVER_TICKS - 1);

   logic          tick;
   logic          toggle;

   logic [HW-1:0] hold_cnt_reg;
   logic          armed_reg;

   state_t        state_reg,  state_next;
   logic [1:0]    target_reg, target_next;
   logic [OW-1:0] ho_cnt_reg, ho_cnt_next;

   logic [3:0]    motion_next;
   logic [3:0]    motion_reg;
   logic          power_on_reg;
   logic          manual_mode_on_reg;
   logic          semi_auto_mode_on_reg;
   logic          auto_mode_on_reg;

   tick_gen #(.DIV(TICK_DIV)) u_tick_gen (
      .clk   (clk),
      .reset (reset),
      .tick  (tick)
   );

   // Fires in the tick cycle that would bring the hold count up to
   // POWER_HOLD_TICKS; the state changes on that same edge.
   assign toggle = power_button && armed_reg && tick && (hold_cnt_reg == HOLD_LAST);

   // Long-press detector. armed drops after a toggle so a button that keeps
   // being held cannot toggle again until it has been released.
   always_ff @(posedge clk) begin
      if (reset) begin
         hold_cnt_reg <= '0;
         armed_reg    <= 1'b1;
      end else if (!power_button) begin
         hold_cnt_reg <= '0;
         armed_reg    <= 1'b1;
      end else if (tick && armed_reg) begin
         if (toggle) begin
            hold_cnt_reg <= '0;
            armed_reg    <= 1'b0;
         end else begin
            hold_cnt_reg <= hold_cnt_reg + 1'b1;
         end
      end
   end

   // Next state. Power toggle outranks a mode change, which outranks
   // handover completion.
   always_comb begin
      state_next  = state_reg;
      target_next = target_reg;
      ho_cnt_next = ho_cnt_reg;
      if (toggle) begin
         state_next  = (state_reg == ST_OFF) ? ST_IDLE : ST_OFF;
         ho_cnt_next = '0;
      end else begin
         case (state_reg)
            ST_OFF: begin
            end
            ST_IDLE: begin
               if (bus.mode_sel != SEL_NONE) begin
                  target_next = bus.mode_sel;
                  state_next  = ST_HANDOVER;
                  ho_cnt_next = '0;
               end
            end
            ST_MANUAL, ST_SEMI, ST_AUTO: begin
               if (bus.mode_sel != sel_for_state(state_reg)) begin
                  target_next = bus.mode_sel;
                  state_next  = ST_HANDOVER;
                  ho_cnt_next = '0;
               end
            end
            ST_HANDOVER: begin
               // A changed request restarts the full stop period.
               if (bus.mode_sel != target_reg) begin
                  target_next = bus.mode_sel;
                  ho_cnt_next = '0;
               end else if (tick) begin
                  if (ho_cnt_reg == HO_LAST) begin
                     state_next  = state_for_sel(target_reg);
                     ho_cnt_next = '0;
                  end else begin
                     ho_cnt_next = ho_cnt_reg + 1'b1;
                  end
               end
            end
            default: begin
               state_next  = ST_OFF;
               ho_cnt_next = '0;
            end
         endcase
      end
   end

   // Outputs are decoded from the next state so that they change on the same
   // edge as the state, and the motors follow the command with one clk delay.
   always_comb begin
      motion_next = '0;
      case (state_next)
         ST_MANUAL: motion_next = mask_cmd(bus.manual_cmd);
         ST_SEMI:   motion_next = mask_cmd(bus.semi_cmd);
         ST_AUTO:   motion_next = mask_cmd(bus.auto_cmd);
         default:   motion_next = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg             <= ST_OFF;
         target_reg            <= SEL_NONE;
         ho_cnt_reg            <= '0;
         motion_reg            <= '0;
         power_on_reg          <= 1'b0;
         manual_mode_on_reg    <= 1'b0;
         semi_auto_mode_on_reg <= 1'b0;
         auto_mode_on_reg      <= 1'b0;
      end else begin
         state_reg             <= state_next;
         target_reg            <= target_next;
         ho_cnt_reg            <= ho_cnt_next;
         motion_reg            <= motion_next;
         power_on_reg          <= (state_next != ST_OFF);
         manual_mode_on_reg    <= (state_next == ST_MANUAL);
         semi_auto_mode_on_reg <= (state_next == ST_SEMI);
         auto_mode_on_reg      <= (state_next == ST_AUTO);
      end
   end

   assign bus.power_on          = power_on_reg;
   assign bus.manual_mode_on    = manual_mode_on_reg;
   assign bus.semi_auto_mode_on = semi_auto_mode_on_reg;
   assign bus.auto_mode_on      = auto_mode_on_reg;
   assign bus.move_backward     = motion_reg[CMD_BWD];
   assign bus.move_forward      = motion_reg[CMD_FWD];
   assign bus.turn_left         = motion_reg[CMD_LEFT];
   assign bus.turn_right        = motion_reg[CMD_RIGHT];
   assign bus.mode_state        = state_reg;
endmodule

// File: tb/tb_drive_mode_arbiter.sv
// Scoreboard bench for drive_mode_arbiter. Each cycle the driver applies
// inputs on the falling edge, advances a behavioural model of the car's mode
// rules and queues the outputs expected after the next rising edge; a separate
// monitor pops and compares them just after that edge.
module tb_drive_mode_arbiter;
   localparam int TD = 4;   // clk per tick
   localparam int PH = 3;   // ticks to toggle power
   localparam int HT = 2;   // ticks of handover stop

   logic clk          = 1'b0;
   logic reset        = 1'b1;
   logic power_button = 1'b0;

   drive_mode_arbiter_if bus ();

   drive_mode_arbiter #(
      .TICK_DIV         (TD),
      .POWER_HOLD_TICKS (PH),
      .HANDOVER_TICKS   (HT)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .power_button (power_button),
      .bus          (bus)
   );

   always #5 clk = ~clk;

   // Model: mode numbers follow the LED codes (0 off, 1 idle, 2 handover,
   // 3 manual, 4 semi, 5 auto); an active mode n is selected by code n-2.
   int         m_cycles;     // clk cycles since reset release
   int         m_held;       // whole ticks the button has been held
   bit         m_armed;
   int         m_mode;
   int         m_target;
   int         m_stop_ticks; // whole ticks spent stopped for the current target
   logic [10:0] exp_q[$];

   int checks = 0;
   int passed = 0;
   int step_no = 0;

   function automatic logic [3:0] clean(input logic [3:0] c);
      logic [3:0] r;
      r = c;
      if (c[3] && c[2]) r[3:2] = 2'b00;
      if (c[1] && c[0]) r[1:0] = 2'b00;
      return r;
   endfunction

   task automatic step(input logic btn, input logic [1:0] sel, input logic [3:0] mc,
                       input logic [3:0] sc, input logic [3:0] ac, input logic rst);
      bit         is_tick;
      bit         fire;
      int         sel_i;
      logic [3:0] motors;
      logic [2:0] code;
      @(negedge clk);
      reset          = rst;
      power_button   = btn;
      bus.mode_sel   = sel;
      bus.manual_cmd = mc;
      bus.semi_cmd   = sc;
      bus.auto_cmd   = ac;
      sel_i = int'(sel);
      if (rst) begin
         m_cycles = 0; m_held = 0; m_armed = 1'b1;
         m_mode = 0; m_target = 0; m_stop_ticks = 0;
      end else begin
         is_tick  = ((m_cycles % TD) == TD - 1);
         m_cycles = m_cycles + 1;
         fire = 1'b0;
         if (!btn) begin
            m_held = 0; m_armed = 1'b1;
         end else if (is_tick && m_armed) begin
            m_held = m_held + 1;
            if (m_held == PH) begin
               fire = 1'b1; m_held = 0; m_armed = 1'b0;
            end
         end
         if (fire) begin
            m_mode = (m_mode == 0) ? 1 : 0;
         end else if (m_mode == 1 && sel_i != 0) begin
            m_target = sel_i; m_mode = 2; m_stop_ticks = 0;
         end else if (m_mode >= 3 && sel_i != m_mode - 2) begin
            m_target = sel_i; m_mode = 2; m_stop_ticks = 0;
         end else if (m_mode == 2) begin
            if (sel_i != m_target) begin
               m_target = sel_i; m_stop_ticks = 0;
            end else if (is_tick) begin
               m_stop_ticks = m_stop_ticks + 1;
               if (m_stop_ticks == HT) begin
                  m_mode = (m_target == 0) ? 1 : m_target + 2;
                  m_stop_ticks = 0;
               end
            end
         end
      end
      motors = (m_mode == 3) ? clean(mc) : (m_mode == 4) ? clean(sc) :
               (m_mode == 5) ? clean(ac) : 4'b0000;
      code = 3'(m_mode);
      exp_q.push_back({m_mode != 0, m_mode == 3, m_mode == 4, m_mode == 5, motors, code});
   endtask

   task automatic hold(input int n, input logic btn, input logic [1:0] sel,
                       input logic [3:0] mc, input logic rst);
      for (int i = 0; i < n; i++) step(btn, sel, mc, 4'h0, 4'h0, rst);
   endtask

   // Monitor
   initial begin
      logic [10:0] act;
      logic [10:0] exp_v;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            act = {bus.power_on, bus.manual_mode_on, bus.semi_auto_mode_on, bus.auto_mode_on,
                   bus.move_backward, bus.move_forward, bus.turn_left, bus.turn_right,
                   bus.mode_state};
            checks++;
            step_no++;
            if (act !== exp_v)
               $display("FAIL outputs step %0d: got pwr/en/mot/state=%b expected %b",
                        step_no, act, exp_v);
            else
               passed++;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int seg_len;
      logic btn;
      logic [1:0] sel;
      bus.mode_sel = 2'b00; bus.manual_cmd = 4'h0; bus.semi_cmd = 4'h0; bus.auto_cmd = 4'h0;

      hold(3, 1'b0, 2'b00, 4'h0, 1'b1);
      hold(5, 1'b0, 2'b01, 4'hF, 1'b0);
      $display("phase reset: OFF expected, mode_sel ignored");
      hold(8, 1'b1, 2'b00, 4'h0, 1'b0);
      hold(6, 1'b0, 2'b00, 4'h0, 1'b0);
      $display("phase short press: must stay OFF");
      hold(12, 1'b1, 2'b00, 4'h0, 1'b0);
      hold(40, 1'b1, 2'b00, 4'h0, 1'b0);
      $display("phase power on + long hold: IDLE, no retoggle");
      hold(3, 1'b0, 2'b00, 4'h0, 1'b0);
      hold(12, 1'b1, 2'b00, 4'h0, 1'b0);
      hold(3, 1'b0, 2'b00, 4'h0, 1'b0);
      $display("phase power off: OFF");
      hold(12, 1'b1, 2'b00, 4'h0, 1'b0);
      hold(2, 1'b0, 2'b00, 4'h0, 1'b0);
      hold(15, 1'b0, 2'b01, 4'b0100, 1'b0);
      $display("phase mode entry: handover then MANUAL forward");
      hold(3, 1'b0, 2'b01, 4'b1110, 1'b0);
      hold(3, 1'b0, 2'b01, 4'b0011, 1'b0);
      hold(3, 1'b0, 2'b01, 4'b1001, 1'b0);
      $display("phase conflict masking");
      for (int i = 0; i < 5; i++) step(1'b0, 2'b10, 4'h0, 4'b1000, 4'b0100, 1'b0);
      for (int i = 0; i < 15; i++) step(1'b0, 2'b11, 4'h0, 4'b1000, 4'b0101, 1'b0);
      $display("phase retarget semi->auto during handover");
      hold(3, 1'b0, 2'b00, 4'h0, 1'b0);
      hold(1, 1'b0, 2'b00, 4'h0, 1'b1);
      hold(5, 1'b1, 2'b00, 4'h0, 1'b0);
      $display("phase reset mid-handover");

      for (int s = 0; s < 200; s++) begin
         seg_len = $urandom_range(1, 30);
         btn = ($urandom_range(0, 3) == 0);
         sel = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 39) == 0) begin
            step(btn, sel, 4'($urandom), 4'($urandom), 4'($urandom), 1'b1);
         end
         for (int i = 0; i < seg_len; i++)
            step(btn, sel, 4'($urandom), 4'($urandom), 4'($urandom), 1'b0);
      end
      $display("phase random segments done");

      for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
         checks++;
         $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
      end
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
